// File: rtl/uart_rx_queue_pkg.sv
// rtl/uart_rx_queue_pkg.sv - shared state encodings and queue sizing for the UART receive path
package uart_rx_queue_pkg;

    localparam int DEF_DEPTH_LOG2 = 4;
    localparam int DEF_RD_CYCLES  = 3;
    localparam int DEF_DATA_W     = 8;

    typedef enum logic [2:0] {
        UART_IDLE    = 3'd0,
        UART_REQ     = 3'd1,
        UART_STROBE  = 3'd2,
        UART_CAPTURE = 3'd3,
        UART_RELEASE = 3'd4
    } uart_state_e;

    function automatic int queue_size(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/uart_rx_queue_if.sv
// rtl/uart_rx_queue_if.sv - UART chip handshake, shared bus and queue consumer signals
interface uart_rx_queue_if #(
    parameter int DATA_W     = uart_rx_queue_pkg::DEF_DATA_W,
    parameter int DEPTH_LOG2 = uart_rx_queue_pkg::DEF_DEPTH_LOG2
);
    logic              data_ready;
    logic              rdn;
    logic              bus_req;
    logic              bus_grant;
    logic [15:0]       bus_data;
    logic              pop;
    logic [DATA_W-1:0] q_front;
    logic              q_empty;
    logic              q_full;
    logic [DEPTH_LOG2:0] q_count;
    logic              overflow;
    logic              clr_overflow;

    modport slave (
        input  data_ready, bus_grant, bus_data, pop, clr_overflow,
        output rdn, bus_req, q_front, q_empty, q_full, q_count, overflow
    );

    modport master (
        output data_ready, bus_grant, bus_data, pop, clr_overflow,
        input  rdn, bus_req, q_front, q_empty, q_full, q_count, overflow
    );
endinterface

// File: rtl/uart_rx_queue_rx_fifo.sv
// rtl/uart_rx_queue_rx_fifo.sv - circular receive buffer with wrap-bit pointers and sticky overflow
module uart_rx_queue_rx_fifo
    import uart_rx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              clr_overflow,
    output logic [DATA_W-1:0] front,
    output logic              empty,
    output logic              full,
    output logic [DEPTH_LOG2:0] count,
    output logic              overflow
);
    localparam int DEPTH = queue_size(DEPTH_LOG2);
    localparam int PTR_W = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic              overflow_q, overflow_d;
    logic              do_push, do_pop, drop;

    assign empty = (head_q == tail_q);
    assign full  = (head_q[DEPTH_LOG2-1:0] == tail_q[DEPTH_LOG2-1:0]) &&
                   (head_q[DEPTH_LOG2] != tail_q[DEPTH_LOG2]);
    assign count    = tail_q - head_q;
    assign front    = mem_q[head_q[DEPTH_LOG2-1:0]];
    assign overflow = overflow_q;

    // A pop frees the head slot in the same cycle, so a full queue can still accept the push.
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        drop       = push && full && !do_pop;
        head_d     = head_q + PTR_W'(do_pop);
        tail_d     = tail_q + PTR_W'(do_push);
        overflow_d = overflow_q;
        if (clr_overflow) overflow_d = 1'b0;
        if (drop)         overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_queue.sv
// rtl/uart_rx_queue.sv - UART read-strobe FSM on the shared RAM1 bus feeding the receive queue
module uart_rx_queue
    import uart_rx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int RD_CYCLES  = DEF_RD_CYCLES,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_queue_if.slave io
);
    localparam int CNT_W = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;

    uart_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rdn_q, bus_req_q;
    logic             dr_meta_q, dr_s_q;
    logic             push;
    logic             bus_data_unused;

    assign io.rdn          = rdn_q;
    assign io.bus_req      = bus_req_q;
    assign push            = (state_q == UART_CAPTURE) && io.bus_grant;
    assign bus_data_unused = ^io.bus_data[15:DATA_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dr_meta_q <= 1'b0;
            dr_s_q    <= 1'b0;
        end else begin
            dr_meta_q <= io.data_ready;
            dr_s_q    <= dr_meta_q;
        end
    end

    // Losing the grant mid-read abandons the strobe; the byte is re-read after the next grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= UART_IDLE;
            cnt_q     <= '0;
            rdn_q     <= 1'b1;
            bus_req_q <= 1'b0;
        end else begin
            case (state_q)
                UART_IDLE: begin
                    if (dr_s_q) begin
                        state_q   <= UART_REQ;
                        bus_req_q <= 1'b1;
                    end
                end
                UART_REQ: begin
                    if (io.bus_grant) begin
                        state_q <= UART_STROBE;
                        rdn_q   <= 1'b0;
                        cnt_q   <= CNT_W'(RD_CYCLES - 1);
                    end
                end
                UART_STROBE: begin
                    if (!io.bus_grant) begin
                        state_q <= UART_REQ;
                        rdn_q   <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q <= UART_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                UART_CAPTURE: begin
                    rdn_q <= 1'b1;
                    if (!io.bus_grant) begin
                        state_q <= UART_REQ;
                    end else begin
                        state_q   <= UART_RELEASE;
                        bus_req_q <= 1'b0;
                    end
                end
                UART_RELEASE: begin
                    if (!dr_s_q) state_q <= UART_IDLE;
                end
                default: begin
                    state_q   <= UART_IDLE;
                    rdn_q     <= 1'b1;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    uart_rx_queue_rx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_rx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_data    (io.bus_data[DATA_W-1:0]),
        .pop          (io.pop),
        .clr_overflow (io.clr_overflow),
        .front        (io.q_front),
        .empty        (io.q_empty),
        .full         (io.q_full),
        .count        (io.q_count),
        .overflow     (io.overflow)
    );

endmodule
